// File: rtl/mac_video_gen.sv
// mac_video_gen: compact-Macintosh style video timing generator.
//   Walks an hc/vc raster one step per i_pix_stb, fetches one framebuffer bit
//   per active pixel and emits HSYNC/VSYNC/VIDEO with a fixed two-clock
//   latency from the strobe edge.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_pix_stb         one-clock strobe per emulated pixel period
//   i_fb_data         framebuffer bit (1 = white), valid one clock after o_fb_re
//   o_fb_addr/o_fb_re framebuffer read port, address = {y, x}
//   o_hsync/o_vsync   active-low syncs
//   o_video           1 = black pixel, 0 in blanking
//   o_active          o_video carries an active pixel
//   o_frame           single-clock pulse on the first pixel of each frame
module mac_video_gen #(
  parameter int H_RES    = 512,
  parameter int H_TOTAL  = 704,
  parameter int H_SYNC   = 288,
  parameter int H_START  = 177,
  parameter int V_RES    = 342,
  parameter int V_TOTAL  = 370,
  parameter int V_SYNC   = 4,
  parameter int V_START  = 8,
  parameter int FB_ADDRW = 18
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pix_stb,
  input  logic                i_fb_data,
  output logic [FB_ADDRW-1:0] o_fb_addr,
  output logic                o_fb_re,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_video,
  output logic                o_active,
  output logic                o_frame
);

  // +1 so that end-of-region bounds equal to the total still fit
  localparam int HCW = $clog2(H_TOTAL + 1);
  localparam int VCW = $clog2(V_TOTAL + 1);
  localparam int XW  = FB_ADDRW / 2;

  localparam logic [HCW-1:0] H_LAST  = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_SYN_C = HCW'(H_SYNC);
  localparam logic [HCW-1:0] H_BEG_C = HCW'(H_START);
  localparam logic [HCW-1:0] H_END_C = HCW'(H_START + H_RES);
  localparam logic [VCW-1:0] V_LAST  = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_SYN_C = VCW'(V_SYNC);
  localparam logic [VCW-1:0] V_BEG_C = VCW'(V_SYNC + V_START);
  localparam logic [VCW-1:0] V_END_C = VCW'(V_SYNC + V_START + V_RES);

  if (H_START + H_RES > H_TOTAL || H_SYNC >= H_TOTAL ||
      V_SYNC + V_START + V_RES > V_TOTAL) begin : g_param_err
    $error("mac_video_gen: inconsistent timing parameters");
  end

  logic [HCW-1:0]      hc_q, hc_d;
  logic [VCW-1:0]      vc_q, vc_d;
  // stage 1: flags of the pixel strobed on the previous edge
  logic                stb1_q, stb1_d;
  logic                hs1_q, hs1_d;    // 1 = hsync asserted (low)
  logic                vs1_q, vs1_d;
  logic                act1_q, act1_d;
  logic                frm1_q, frm1_d;
  logic [FB_ADDRW-1:0] addr_q, addr_d;
  logic                re_q, re_d;
  // stage 2: visible outputs
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                video_q, video_d;
  logic                active_q, active_d;
  logic                frame_q, frame_d;

  logic                pos_act;
  logic [XW-1:0]       x_pos, y_pos;

  always_comb begin
    pos_act = (hc_q >= H_BEG_C) && (hc_q < H_END_C) &&
              (vc_q >= V_BEG_C) && (vc_q < V_END_C);
    x_pos   = XW'(hc_q - H_BEG_C);
    y_pos   = XW'(vc_q - V_BEG_C);

    hc_d     = hc_q;
    vc_d     = vc_q;
    stb1_d   = i_pix_stb;
    hs1_d    = hs1_q;
    vs1_d    = vs1_q;
    act1_d   = act1_q;
    frm1_d   = frm1_q;
    addr_d   = addr_q;
    re_d     = 1'b0;

    if (i_pix_stb) begin
      hs1_d  = hc_q < H_SYN_C;
      vs1_d  = vc_q < V_SYN_C;
      act1_d = pos_act;
      frm1_d = (hc_q == '0) && (vc_q == '0);
      if (pos_act) begin
        addr_d = FB_ADDRW'({y_pos, x_pos});
        re_d   = 1'b1;
      end
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end

    // Outputs only move on the clock after a strobe, so they hold between
    // strobes; the frame pulse is the one exception and lasts a single clock.
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    video_d  = video_q;
    active_d = active_q;
    frame_d  = stb1_q & frm1_q;
    if (stb1_q) begin
      hsync_d  = ~hs1_q;
      vsync_d  = ~vs1_q;
      active_d = act1_q;
      video_d  = act1_q & ~i_fb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hc_q     <= '0;
      vc_q     <= '0;
      stb1_q   <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      act1_q   <= 1'b0;
      frm1_q   <= 1'b0;
      addr_q   <= '0;
      re_q     <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      video_q  <= 1'b0;
      active_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      stb1_q   <= stb1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      act1_q   <= act1_d;
      frm1_q   <= frm1_d;
      addr_q   <= addr_d;
      re_q     <= re_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      video_q  <= video_d;
      active_q <= active_d;
      frame_q  <= frame_d;
    end
  end

  assign o_fb_addr = addr_q;
  assign o_fb_re   = re_q;
  assign o_hsync   = hsync_q;
  assign o_vsync   = vsync_q;
  assign o_video   = video_q;
  assign o_active  = active_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_mac_video_gen.sv
// Bench for mac_video_gen: a default-timing instance and a tiny-timing
// instance share one random strobe/reset stream; each is compared every clock
// against a raster model that works on a linear pixel index within the frame.
module tb_mac_video_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stb, junk;

  logic [17:0] addr0, addr1;
  logic        re0, hs0, vs0, vid0, act0, frm0, fb0;
  logic        re1, hs1, vs1, vid1, act1, frm1, fb1;

  // framebuffer pattern: white where x[0]^y[0]; unrelated noise when not read
  assign fb0 = re0 ? (addr0[0] ^ addr0[9]) : junk;
  assign fb1 = re1 ? (addr1[0] ^ addr1[9]) : junk;

  mac_video_gen u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_fb_data(fb0),
    .o_fb_addr(addr0), .o_fb_re(re0), .o_hsync(hs0), .o_vsync(vs0),
    .o_video(vid0), .o_active(act0), .o_frame(frm0));

  mac_video_gen #(
    .H_RES(4), .H_TOTAL(8), .H_SYNC(2), .H_START(3),
    .V_RES(2), .V_TOTAL(6), .V_SYNC(1), .V_START(1)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_pix_stb(stb), .i_fb_data(fb1),
    .o_fb_addr(addr1), .o_fb_re(re1), .o_hsync(hs1), .o_vsync(vs1),
    .o_video(vid1), .o_active(act1), .o_frame(frm1));

  typedef struct {
    int hres, htot, hsyn, hst, vres, vtot, vsyn, vst;
  } cfg_t;

  typedef struct {
    int n;      // next pixel index in frame
    int pend;   // a pixel was strobed on the previous edge
    int pn;     // its index
    int hs, vs, vid, act, frm, re, addr;
  } mst_t;

  cfg_t c0, c1;
  mst_t m0, m1;
  int   n_run, n_fail;
  int   frames0, frames1;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int in_act(cfg_t c, int idx);
    int h = idx % c.htot;
    int v = idx / c.htot;
    return int'(h >= c.hst && h < c.hst + c.hres &&
                v >= c.vsyn + c.vst && v < c.vsyn + c.vst + c.vres);
  endfunction

  function automatic mst_t step(mst_t s, cfg_t c, bit r, bit st);
    mst_t o = s;
    int h, v, x, y;
    o.frm = 0;
    if (r) begin
      o.n = 0; o.pend = 0; o.pn = 0;
      o.hs = 1; o.vs = 1; o.vid = 0; o.act = 0; o.re = 0; o.addr = 0;
      return o;
    end
    if (s.pend != 0) begin
      h = s.pn % c.htot;
      v = s.pn / c.htot;
      x = h - c.hst;
      y = v - c.vsyn - c.vst;
      o.hs  = int'(h >= c.hsyn);
      o.vs  = int'(v >= c.vsyn);
      o.act = in_act(c, s.pn);
      o.vid = (o.act != 0) ? int'(((x ^ y) & 1) == 0) : 0;
      o.frm = int'(s.pn == 0);
    end
    o.pend = int'(st);
    o.re   = 0;
    if (st) begin
      o.pn = s.n;
      o.re = in_act(c, s.n);
      if (o.re != 0)
        o.addr = (((s.n / c.htot) - c.vsyn - c.vst) << 9) | ((s.n % c.htot) - c.hst);
      o.n = (s.n + 1) % (c.htot * c.vtot);
    end
    return o;
  endfunction

  task automatic cyc(input bit r, input bit st);
    rst = r;
    stb = st;
    @(posedge clk);
    m0 = step(m0, c0, r, st);
    m1 = step(m1, c1, r, st);
    #1;
    junk = 1'($urandom);
    chk("hsync0",  int'(hs0),  m0.hs);
    chk("vsync0",  int'(vs0),  m0.vs);
    chk("video0",  int'(vid0), m0.vid);
    chk("active0", int'(act0), m0.act);
    chk("frame0",  int'(frm0), m0.frm);
    chk("fb_re0",  int'(re0),  m0.re);
    chk("fb_addr0", int'(addr0), m0.addr);
    chk("hsync1",  int'(hs1),  m1.hs);
    chk("vsync1",  int'(vs1),  m1.vs);
    chk("video1",  int'(vid1), m1.vid);
    chk("active1", int'(act1), m1.act);
    chk("frame1",  int'(frm1), m1.frm);
    chk("fb_re1",  int'(re1),  m1.re);
    chk("fb_addr1", int'(addr1), m1.addr);
    frames0 += int'(frm0);
    frames1 += int'(frm1);
  endtask

  initial begin
    n_run = 0; n_fail = 0; frames0 = 0; frames1 = 0;
    c0 = '{512, 704, 288, 177, 342, 370, 4, 8};
    c1 = '{4, 8, 2, 3, 2, 6, 1, 1};
    m0 = '{default: 0};
    m1 = '{default: 0};
    rst = 1'b1; stb = 1'b0; junk = 1'b0;

    // reset with strobes present: strobes must be ignored
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'(i & 1));

    // one full default line, strobe every 6 clocks
    for (int i = 0; i < 706 * 6; i++) cyc(1'b0, (i % 6) == 0);

    // random strobe density with a 50-clock freeze mid-line
    for (int i = 0; i < 4000; i++) cyc(1'b0, ($urandom_range(3, 0) != 0));
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) cyc(1'b0, ($urandom_range(3, 0) != 0));

    // mid-line reset, then a strobe every clock into the active region
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 9600; i++) cyc(1'b0, 1'b1);

    // random strobes with occasional resets
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(499, 0) == 0), ($urandom_range(2, 0) != 0));

    // the small instance has covered many frames; each should have pulsed
    chk("frames1_seen", int'(frames1 > 3), 1);
    chk("frames0_seen", int'(frames0 >= 1), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
